// File: rtl/l1_jet_merge.sv
// l1_jet_merge
// ------------
// Layer-1 jet merger. Takes the eta-ordered cluster stream of one event
// from the clusterizer, merges clusters in adjacent eta bins into a single
// held jet, applies a minimum-pT threshold and caps the number of jets
// emitted per event. An end-of-event pulse flushes the held jet and
// produces a one-cycle done pulse with the per-event jet count.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   start             : one-cycle event start, clears per-event state
//   in_valid          : cluster valid
//   in_pt/eta/ntrx/xcount : cluster fields
//   eoe               : end-of-event pulse
//   out_valid         : one cycle per finalized jet
//   out_pt/eta/ntrx/xcount: finalized jet fields
//   out_done          : one-cycle pulse, event fully flushed
//   out_count         : jets emitted this event (meaningful with out_done)
//   overflow          : sticky per event, a jet was dropped by the cap
module l1_jet_merge #(
  parameter logic [8:0] PT_MIN   = 9'd2,
  parameter int         MAX_JETS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [8:0] in_pt,
  input  logic [4:0] in_eta,
  input  logic [4:0] in_ntrx,
  input  logic [3:0] in_xcount,
  input  logic       eoe,
  output logic       out_valid,
  output logic [8:0] out_pt,
  output logic [4:0] out_eta,
  output logic [4:0] out_ntrx,
  output logic [3:0] out_xcount,
  output logic       out_done,
  output logic [3:0] out_count,
  output logic       overflow
);

  localparam logic [3:0] MAX_C = 4'(MAX_JETS);

  typedef enum logic [0:0] {
    ST_ACC   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Saturating adders for the merged jet fields.
  function automatic logic [8:0] sat_add9(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[9]) begin
      sat_add9 = 9'h1FF;
    end else begin
      sat_add9 = s[8:0];
    end
  endfunction

  function automatic logic [4:0] sat_add5(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[5]) begin
      sat_add5 = 5'h1F;
    end else begin
      sat_add5 = s[4:0];
    end
  endfunction

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[4]) begin
      sat_add4 = 4'hF;
    end else begin
      sat_add4 = s[3:0];
    end
  endfunction

  // Registered state
  state_t     state_r;
  logic       hvalid_r;
  logic [8:0] hpt_r;
  logic [4:0] heta_r;
  logic [4:0] hlast_r;
  logic [8:0] hmax_r;
  logic [4:0] hntrx_r;
  logic [3:0] hnx_r;
  logic [3:0] count_r;
  logic       overflow_r;
  logic       out_valid_r;
  logic [8:0] out_pt_r;
  logic [4:0] out_eta_r;
  logic [4:0] out_ntrx_r;
  logic [3:0] out_xcount_r;
  logic       out_done_r;

  // Next-state values
  state_t     state_s;
  logic       hvalid_s;
  logic [8:0] hpt_s;
  logic [4:0] heta_s;
  logic [4:0] hlast_s;
  logic [8:0] hmax_s;
  logic [4:0] hntrx_s;
  logic [3:0] hnx_s;
  logic [3:0] count_s;
  logic       overflow_s;
  logic       out_valid_s;
  logic [8:0] out_pt_s;
  logic [4:0] out_eta_s;
  logic [4:0] out_ntrx_s;
  logic [3:0] out_xcount_s;
  logic       out_done_s;

  // Jet selected for finalization this cycle (threshold/cap applied after)
  logic       fin_req_s;
  logic [8:0] fin_pt_s;
  logic [4:0] fin_eta_s;
  logic [4:0] fin_ntrx_s;
  logic [3:0] fin_nx_s;
  logic       adjacent_s;

  // Eta compared in 6 bits so that bin 31 followed by bin 0 never merges.
  assign adjacent_s = hvalid_r && ({1'b0, in_eta} == ({1'b0, hlast_r} + 6'd1));

  // Next-state and output decode: merge/load, finalize, threshold and cap.
  always_comb begin
    state_s      = state_r;
    hvalid_s     = hvalid_r;
    hpt_s        = hpt_r;
    heta_s       = heta_r;
    hlast_s      = hlast_r;
    hmax_s       = hmax_r;
    hntrx_s      = hntrx_r;
    hnx_s        = hnx_r;
    count_s      = count_r;
    overflow_s   = overflow_r;
    out_valid_s  = 1'b0;
    out_pt_s     = out_pt_r;
    out_eta_s    = out_eta_r;
    out_ntrx_s   = out_ntrx_r;
    out_xcount_s = out_xcount_r;
    out_done_s   = 1'b0;
    fin_req_s    = 1'b0;
    fin_pt_s     = hpt_r;
    fin_eta_s    = heta_r;
    fin_ntrx_s   = hntrx_r;
    fin_nx_s     = hnx_r;

    if (start) begin
      // Start wins over every same-cycle input; any held jet is discarded.
      state_s    = ST_ACC;
      hvalid_s   = 1'b0;
      count_s    = 4'd0;
      overflow_s = 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (in_valid) begin
            if (adjacent_s) begin
              hpt_s   = sat_add9(hpt_r, in_pt);
              hntrx_s = sat_add5(hntrx_r, in_ntrx);
              hnx_s   = sat_add4(hnx_r, in_xcount);
              hlast_s = in_eta;
              // Strictly greater: a pT tie keeps the earlier eta.
              if (in_pt > hmax_r) begin
                heta_s = in_eta;
                hmax_s = in_pt;
              end else begin
                heta_s = heta_r;
                hmax_s = hmax_r;
              end
            end else begin
              // Non-adjacent: the old held jet (if any) goes out now.
              fin_req_s = hvalid_r;
              hvalid_s  = 1'b1;
              hpt_s     = in_pt;
              heta_s    = in_eta;
              hlast_s   = in_eta;
              hmax_s    = in_pt;
              hntrx_s   = in_ntrx;
              hnx_s     = in_xcount;
            end
          end else begin
            hvalid_s = hvalid_r;
          end

          if (eoe) begin
            if (fin_req_s) begin
              // Output slot already used by the old jet: flush next cycle.
              state_s = ST_FLUSH;
            end else begin
              if (hvalid_s) begin
                fin_req_s  = 1'b1;
                fin_pt_s   = hpt_s;
                fin_eta_s  = heta_s;
                fin_ntrx_s = hntrx_s;
                fin_nx_s   = hnx_s;
                hvalid_s   = 1'b0;
              end else begin
                fin_req_s = 1'b0;
              end
              out_done_s = 1'b1;
            end
          end else begin
            state_s = ST_ACC;
          end
        end

        ST_FLUSH: begin
          // in_valid and eoe are ignored here.
          fin_req_s  = hvalid_r;
          hvalid_s   = 1'b0;
          out_done_s = 1'b1;
          state_s    = ST_ACC;
        end

        default: begin
          state_s  = ST_ACC;
          hvalid_s = 1'b0;
        end
      endcase

      if (fin_req_s) begin
        if (fin_pt_s < PT_MIN) begin
          // Below threshold: dropped silently, not counted.
          out_valid_s = 1'b0;
        end else if (count_r == MAX_C) begin
          overflow_s = 1'b1;
        end else begin
          out_valid_s  = 1'b1;
          out_pt_s     = fin_pt_s;
          out_eta_s    = fin_eta_s;
          out_ntrx_s   = fin_ntrx_s;
          out_xcount_s = fin_nx_s;
          count_s      = count_r + 4'd1;
        end
      end else begin
        out_valid_s = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACC;
    end else begin
      state_r <= state_s;
    end
  end

  // Held jet, per-event counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hvalid_r     <= 1'b0;
      hpt_r        <= 9'd0;
      heta_r       <= 5'd0;
      hlast_r      <= 5'd0;
      hmax_r       <= 9'd0;
      hntrx_r      <= 5'd0;
      hnx_r        <= 4'd0;
      count_r      <= 4'd0;
      overflow_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_pt_r     <= 9'd0;
      out_eta_r    <= 5'd0;
      out_ntrx_r   <= 5'd0;
      out_xcount_r <= 4'd0;
      out_done_r   <= 1'b0;
    end else begin
      hvalid_r     <= hvalid_s;
      hpt_r        <= hpt_s;
      heta_r       <= heta_s;
      hlast_r      <= hlast_s;
      hmax_r       <= hmax_s;
      hntrx_r      <= hntrx_s;
      hnx_r        <= hnx_s;
      count_r      <= count_s;
      overflow_r   <= overflow_s;
      out_valid_r  <= out_valid_s;
      out_pt_r     <= out_pt_s;
      out_eta_r    <= out_eta_s;
      out_ntrx_r   <= out_ntrx_s;
      out_xcount_r <= out_xcount_s;
      out_done_r   <= out_done_s;
    end
  end

  // count_r and overflow_r already include the jet emitted alongside out_done.
  assign out_valid  = out_valid_r;
  assign out_pt     = out_pt_r;
  assign out_eta    = out_eta_r;
  assign out_ntrx   = out_ntrx_r;
  assign out_xcount = out_xcount_r;
  assign out_done   = out_done_r;
  assign out_count  = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_l1_jet_merge.sv
// Directed testbench for l1_jet_merge (PT_MIN=2, MAX_JETS=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the edge that registered them.
module tb_l1_jet_merge;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [8:0] in_pt;
  logic [4:0] in_eta;
  logic [4:0] in_ntrx;
  logic [3:0] in_xcount;
  logic       eoe;
  logic       out_valid;
  logic [8:0] out_pt;
  logic [4:0] out_eta;
  logic [4:0] out_ntrx;
  logic [3:0] out_xcount;
  logic       out_done;
  logic [3:0] out_count;
  logic       overflow;

  int checks;
  int failures;

  l1_jet_merge #(
    .PT_MIN   (9'd2),
    .MAX_JETS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_pt      (in_pt),
    .in_eta     (in_eta),
    .in_ntrx    (in_ntrx),
    .in_xcount  (in_xcount),
    .eoe        (eoe),
    .out_valid  (out_valid),
    .out_pt     (out_pt),
    .out_eta    (out_eta),
    .out_ntrx   (out_ntrx),
    .out_xcount (out_xcount),
    .out_done   (out_done),
    .out_count  (out_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [8:0] pt, input logic [4:0] eta,
                       input logic [4:0] nt, input logic [3:0] xc,
                       input logic e, input logic s);
    in_valid  = v;
    in_pt     = pt;
    in_eta    = eta;
    in_ntrx   = nt;
    in_xcount = xc;
    eoe       = e;
    start     = s;
  endtask

  task automatic idle();
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_jet(input string tag, input logic [8:0] pt, input logic [4:0] eta,
                         input logic [4:0] nt, input logic [3:0] xc);
    chk({tag, ".valid"},  {15'd0, out_valid}, 16'd1);
    chk({tag, ".pt"},     {7'd0, out_pt},     {7'd0, pt});
    chk({tag, ".eta"},    {11'd0, out_eta},   {11'd0, eta});
    chk({tag, ".ntrx"},   {11'd0, out_ntrx},  {11'd0, nt});
    chk({tag, ".xcount"}, {12'd0, out_xcount}, {12'd0, xc});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, ".done"},  {15'd0, out_done},  16'd0);
  endtask

  task automatic chk_done(input string tag, input logic [3:0] cnt, input logic ovf);
    chk({tag, ".done"},     {15'd0, out_done},  16'd1);
    chk({tag, ".count"},    {12'd0, out_count}, {12'd0, cnt});
    chk({tag, ".overflow"}, {15'd0, overflow},  {15'd0, ovf});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();

    // Reset state
    cyc();
    cyc();
    chk("rst.valid",    {15'd0, out_valid},  16'd0);
    chk("rst.pt",       {7'd0, out_pt},      16'd0);
    chk("rst.eta",      {11'd0, out_eta},    16'd0);
    chk("rst.ntrx",     {11'd0, out_ntrx},   16'd0);
    chk("rst.xcount",   {12'd0, out_xcount}, 16'd0);
    chk("rst.done",     {15'd0, out_done},   16'd0);
    chk("rst.count",    {12'd0, out_count},  16'd0);
    chk("rst.overflow", {15'd0, overflow},   16'd0);
    reset = 1'b0;

    // Adjacent merge across a gap cycle, merged jet emitted with eoe
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    chk_quiet("m.start");
    drive(1'b1, 9'd20, 5'd5, 5'd3, 4'd1, 1'b0, 1'b0); cyc();
    chk_quiet("m.c0");
    idle(); cyc();
    chk_quiet("m.gap");
    drive(1'b1, 9'd8, 5'd6, 5'd4, 4'd2, 1'b1, 1'b0); cyc();
    chk_jet("m.jet", 9'd28, 5'd5, 5'd7, 4'd3);
    chk_done("m.end", 4'd1, 1'b0);
    idle(); cyc();
    chk_quiet("m.after");

    // Max-pT eta selection and saturation of every field
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    drive(1'b1, 9'd300, 5'd3, 5'd20, 4'd9, 1'b0, 1'b0); cyc();
    drive(1'b1, 9'd400, 5'd4, 5'd20, 4'd9, 1'b0, 1'b0); cyc();
    chk_quiet("s.mid");
    drive(1'b1, 9'd10, 5'd5, 5'd0, 4'd0, 1'b1, 1'b0); cyc();
    chk_jet("s.jet", 9'd511, 5'd4, 5'd31, 4'd15);
    chk_done("s.end", 4'd1, 1'b0);
    idle(); cyc();

    // Non-adjacent cluster together with eoe: two jets on consecutive cycles
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    drive(1'b1, 9'd50, 5'd2, 5'd1, 4'd0, 1'b0, 1'b0); cyc();
    chk_quiet("n.c0");
    drive(1'b1, 9'd60, 5'd9, 5'd2, 4'd1, 1'b1, 1'b0); cyc();
    chk_jet("n.jet0", 9'd50, 5'd2, 5'd1, 4'd0);
    chk("n.nodone0", {15'd0, out_done}, 16'd0);
    chk("n.count0",  {12'd0, out_count}, 16'd1);
    idle(); cyc();
    chk_jet("n.jet1", 9'd60, 5'd9, 5'd2, 4'd1);
    chk_done("n.end", 4'd2, 1'b0);
    idle(); cyc();
    chk_quiet("n.after");

    // Threshold drop and jet cap (MAX_JETS=2)
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    chk("t.count0", {12'd0, out_count}, 16'd0);
    drive(1'b1, 9'd1, 5'd0, 5'd1, 4'd0, 1'b0, 1'b0); cyc();
    drive(1'b1, 9'd30, 5'd3, 5'd2, 4'd0, 1'b0, 1'b0); cyc();
    chk_quiet("t.lowpt");
    chk("t.lowcnt", {12'd0, out_count}, 16'd0);
    drive(1'b1, 9'd30, 5'd6, 5'd2, 4'd0, 1'b0, 1'b0); cyc();
    chk_jet("t.jet0", 9'd30, 5'd3, 5'd2, 4'd0);
    drive(1'b1, 9'd30, 5'd9, 5'd2, 4'd0, 1'b0, 1'b0); cyc();
    chk_jet("t.jet1", 9'd30, 5'd6, 5'd2, 4'd0);
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0); cyc();
    chk("t.capped", {15'd0, out_valid}, 16'd0);
    chk_done("t.end", 4'd2, 1'b1);
    idle(); cyc();

    // Mid-event start discards the held jet and clears overflow
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    chk("r.ovfclr", {15'd0, overflow}, 16'd0);
    drive(1'b1, 9'd40, 5'd7, 5'd1, 4'd0, 1'b0, 1'b0); cyc();
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    chk_quiet("r.start");
    drive(1'b1, 9'd5, 5'd8, 5'd1, 4'd1, 1'b1, 1'b0); cyc();
    chk_jet("r.jet", 9'd5, 5'd8, 5'd1, 4'd1);
    chk_done("r.end", 4'd1, 1'b0);
    idle(); cyc();

    // Eta 31 followed by eta 0 is not adjacent
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    drive(1'b1, 9'd10, 5'd31, 5'd1, 4'd0, 1'b0, 1'b0); cyc();
    drive(1'b1, 9'd12, 5'd0, 5'd2, 4'd1, 1'b1, 1'b0); cyc();
    chk_jet("w.jet0", 9'd10, 5'd31, 5'd1, 4'd0);
    idle(); cyc();
    chk_jet("w.jet1", 9'd12, 5'd0, 5'd2, 4'd1);
    chk_done("w.end", 4'd2, 1'b0);
    idle(); cyc();

    // Synchronous reset while a jet is held, with a competing eoe
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1); cyc();
    drive(1'b1, 9'd15, 5'd4, 5'd3, 4'd2, 1'b0, 1'b0); cyc();
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    chk("x.valid", {15'd0, out_valid},   16'd0);
    chk("x.pt",    {7'd0, out_pt},       16'd0);
    chk("x.eta",   {11'd0, out_eta},     16'd0);
    chk("x.done",  {15'd0, out_done},    16'd0);
    chk("x.count", {12'd0, out_count},   16'd0);
    reset = 1'b0;
    idle(); cyc();
    chk_quiet("x.idle");
    drive(1'b0, 9'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0); cyc();
    chk("x.nojet", {15'd0, out_valid}, 16'd0);
    chk_done("x.end", 4'd0, 1'b0);
    idle(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
